sisc_fetch_unit: RTL and testbench

- Datapath-side responder to the SISC control FSM. Owns the PC and the instruction register (IR), and acts on the control FSM's fetch and branch strobes.
- Fetches instruction words from instruction memory over a req/ack handshake.
- Decodes the IR fields (opcode, mm, immediate) that the control FSM consumes.
- Sits between the control FSM, instruction memory and the register-file/ALU datapath.

---
 rtl/sisc_pkg.sv | 35 +++
 rtl/sisc_fetch_unit_if.sv | 25 ++
 rtl/sisc_next_pc.sv | 38 +++
 rtl/sisc_fetch_unit.sv | 135 +++++++++++++
 tb/tb_sisc_fetch_unit.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/sisc_pkg.sv
// Shared definitions for the SISC fetch unit: opcode values, IR field
// positions, fetch FSM encoding and the immediate addressing-mode code.
package sisc_pkg;

    // Opcode values carried in ir[31:28]
    localparam logic [3:0] OP_NOOP   = 4'd0;
    localparam logic [3:0] OP_LOD    = 4'd1;
    localparam logic [3:0] OP_STR    = 4'd2;
    localparam logic [3:0] OP_SWP    = 4'd3;
    localparam logic [3:0] OP_BRA    = 4'd4;
    localparam logic [3:0] OP_BRR    = 4'd5;
    localparam logic [3:0] OP_BNE    = 4'd6;
    localparam logic [3:0] OP_BNR    = 4'd7;
    localparam logic [3:0] OP_ALU_OP = 4'd8;
    localparam logic [3:0] OP_HLT    = 4'd15;

    // Addressing mode code for an immediate operand
    localparam logic [3:0] AM_IMM = 4'd8;

    // IR field bit positions
    localparam int OPC_MSB = 31;
    localparam int OPC_LSB = 28;
    localparam int MM_MSB  = 27;
    localparam int MM_LSB  = 24;
    localparam int IMM_MSB = 15;
    localparam int IMM_LSB = 0;

    // Fetch FSM encoding
    typedef enum logic [1:0] {
        FS_IDLE = 2'd0,
        FS_REQ  = 2'd1,
        FS_DONE = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/sisc_fetch_unit_if.sv
// Instruction-memory req/ack bus between the fetch unit (master) and
// instruction memory (slave). Address is held stable while req is high.
interface sisc_fetch_unit_if #(
    parameter int PC_W    = 16,
    parameter int INSTR_W = 32
);
    logic               imem_req;
    logic [PC_W-1:0]    imem_addr;
    logic [INSTR_W-1:0] imem_rdata;
    logic               imem_ack;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rdata,
        input  imem_ack
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rdata,
        output imem_ack
    );
endinterface

// File: rtl/sisc_next_pc.sv
// Combinational next-PC selection: clear, increment, absolute branch or
// PC-relative branch with a sign-extended 16-bit immediate. Wraps mod 2^PC_W.
module sisc_next_pc #(
    parameter int PC_W     = 16,
    parameter int RESET_PC = 0
) (
    input  logic [PC_W-1:0] pc,
    input  logic [15:0]     imm,
    input  logic            pc_rst,
    input  logic            pc_write,
    input  logic            pc_sel,
    input  logic            br_sel,
    output logic [PC_W-1:0] pc_nxt
);
    logic signed [15:0]     imm_s;
    logic signed [PC_W-1:0] imm_sx;
    logic [PC_W-1:0]        imm_abs;

    assign imm_s   = imm;
    assign imm_sx  = PC_W'(imm_s);
    assign imm_abs = PC_W'(imm);

    // Priority: clear, then increment, then absolute, then relative branch
    always_comb begin
        pc_nxt = pc;
        if (pc_rst) begin
            pc_nxt = PC_W'(RESET_PC);
        end else if (pc_write) begin
            if (!pc_sel) begin
                pc_nxt = pc + PC_W'(1);
            end else if (!br_sel) begin
                pc_nxt = imm_abs;
            end else begin
                pc_nxt = pc + $unsigned(imm_sx);
            end
        end
    end
endmodule

// File: rtl/sisc_fetch_unit.sv
// SISC fetch unit: owns PC and IR, fetches over a req/ack bus and decodes
// opcode/mm/imm for the control FSM.
// Optional build macro SISC_FETCH_TIMEOUT_EN adds a fetch timeout that
// returns a NOOP and raises a sticky fetch_err.
module sisc_fetch_unit
    import sisc_pkg::*;
#(
    parameter int PC_W     = 16,
    parameter int INSTR_W  = 32,
    parameter int RESET_PC = 0,
    parameter int TIMEOUT  = 15
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               pc_rst,
    input  logic               pc_write,
    input  logic               pc_sel,
    input  logic               br_sel,
    input  logic               ir_load,
    sisc_fetch_unit_if.master  imem,
    output logic [PC_W-1:0]    pc,
    output logic [INSTR_W-1:0] ir,
    output logic [3:0]         opcode,
    output logic [3:0]         mm,
    output logic [15:0]        imm,
    output logic               ir_valid,
    output logic               fetch_busy,
    output logic               fetch_ovr,
    output logic               fetch_err
);
    fetch_state_e    state, state_nxt;
    logic [PC_W-1:0] pc_nxt;
    logic [PC_W-1:0] addr_q;
    logic            accept;
    logic            take_ack;
    logic            timeout;

    assign opcode = ir[OPC_MSB:OPC_LSB];
    assign mm     = ir[MM_MSB:MM_LSB];
    assign imm    = ir[IMM_MSB:IMM_LSB];

    assign accept     = ir_load && (state == FS_IDLE || state == FS_DONE);
    assign take_ack   = (state == FS_REQ) && imem.imem_ack;
    assign fetch_busy = (state == FS_REQ);
    assign imem.imem_req  = (state == FS_REQ);
    assign imem.imem_addr = addr_q;

    sisc_next_pc #(
        .PC_W     (PC_W),
        .RESET_PC (RESET_PC)
    ) u_next_pc (
        .pc       (pc),
        .imm      (imm),
        .pc_rst   (pc_rst),
        .pc_write (pc_write),
        .pc_sel   (pc_sel),
        .br_sel   (br_sel),
        .pc_nxt   (pc_nxt)
    );

    // PC register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) pc <= PC_W'(RESET_PC);
        else     pc <= pc_nxt;
    end

    // Fetch FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= FS_IDLE;
        else     state <= state_nxt;
    end

    // Fetch FSM next state; an ack wins over a same-cycle timeout
    always_comb begin
        state_nxt = state;
        case (state)
            FS_IDLE: if (ir_load) state_nxt = FS_REQ;
            FS_REQ: begin
                if (imem.imem_ack) state_nxt = FS_DONE;
                else if (timeout)  state_nxt = FS_IDLE;
            end
            FS_DONE: state_nxt = ir_load ? FS_REQ : FS_IDLE;
            default: state_nxt = FS_IDLE;
        endcase
    end

    // Fetch address capture (pre-update PC), IR load and status pulses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q    <= '0;
            ir        <= '0;
            ir_valid  <= 1'b0;
            fetch_ovr <= 1'b0;
        end else begin
            ir_valid  <= 1'b0;
            fetch_ovr <= ir_load && (state == FS_REQ);
            if (accept) addr_q <= pc;
            if (take_ack) begin
                ir       <= imem.imem_rdata;
                ir_valid <= 1'b1;
            end else if (timeout) begin
                ir       <= '0;
                ir_valid <= 1'b1;
            end
        end
    end

`ifdef SISC_FETCH_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] to_cnt;
    logic             err_q;

    assign timeout   = (state == FS_REQ) && !imem.imem_ack &&
                       (to_cnt == CNT_W'(TIMEOUT - 1));
    assign fetch_err = err_q;

    // Wait counter restarts on each accepted fetch; error is sticky until rst
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            to_cnt <= '0;
            err_q  <= 1'b0;
        end else begin
            if (accept)                to_cnt <= '0;
            else if (state == FS_REQ)  to_cnt <= to_cnt + CNT_W'(1);
            if (timeout)               err_q  <= 1'b1;
        end
    end
`else
    logic timeout_unused;
    assign timeout_unused = (TIMEOUT != 0);
    assign timeout   = 1'b0;
    assign fetch_err = 1'b0;
`endif

endmodule

// File: tb/tb_sisc_fetch_unit.sv
// Directed bench for sisc_fetch_unit; hand-computed expectations.
module tb_sisc_fetch_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pc_rst = 1'b0, pc_write = 1'b0, pc_sel = 1'b0;
    logic        br_sel = 1'b0, ir_load = 1'b0;
    logic [15:0] pc;
    logic [31:0] ir;
    logic [3:0]  opcode, mm;
    logic [15:0] imm;
    logic        ir_valid, fetch_busy, fetch_ovr, fetch_err;
    int          n_cmp = 0;
    int          n_bad = 0;

    sisc_fetch_unit_if #(.PC_W(16), .INSTR_W(32)) imem_if ();

    sisc_fetch_unit #(.PC_W(16), .INSTR_W(32), .RESET_PC(0), .TIMEOUT(15)) dut (
        .clk        (clk),
        .rst        (rst),
        .pc_rst     (pc_rst),
        .pc_write   (pc_write),
        .pc_sel     (pc_sel),
        .br_sel     (br_sel),
        .ir_load    (ir_load),
        .imem       (imem_if),
        .pc         (pc),
        .ir         (ir),
        .opcode     (opcode),
        .mm         (mm),
        .imm        (imm),
        .ir_valid   (ir_valid),
        .fetch_busy (fetch_busy),
        .fetch_ovr  (fetch_ovr),
        .fetch_err  (fetch_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue ir_load, wait, ack with data, check the single ir_valid pulse
    task automatic do_fetch(input logic [31:0] data, input int waits, input logic [15:0] exp_addr);
        ir_load = 1'b1;
        tick();
        ir_load = 1'b0;
        check("req_up", imem_if.imem_req, 1);
        check("addr", imem_if.imem_addr, exp_addr);
        check("busy_up", fetch_busy, 1);
        repeat (waits) tick();
        check("req_hold", imem_if.imem_req, 1);
        imem_if.imem_ack   = 1'b1;
        imem_if.imem_rdata = data;
        tick();
        imem_if.imem_ack   = 1'b0;
        check("ir_valid_hi", ir_valid, 1);
        check("ir", ir, data);
        check("req_down", imem_if.imem_req, 0);
        check("busy_done", fetch_busy, 0);
        tick();
        check("ir_valid_lo", ir_valid, 0);
    endtask

    task automatic pc_op(input logic sel, input logic bsel);
        pc_write = 1'b1;
        pc_sel   = sel;
        br_sel   = bsel;
        tick();
        pc_write = 1'b0;
        pc_sel   = 1'b0;
        br_sel   = 1'b0;
    endtask

    initial begin
        imem_if.imem_ack   = 1'b0;
        imem_if.imem_rdata = 32'h0;
        tick();
        tick();
        check("rst_pc", pc, 0);
        check("rst_ir", ir, 0);
        check("rst_req", imem_if.imem_req, 0);
        check("rst_addr", imem_if.imem_addr, 0);
        check("rst_valid", ir_valid, 0);
        check("rst_busy", fetch_busy, 0);
        check("rst_ovr", fetch_ovr, 0);
        check("rst_err", fetch_err, 0);
        rst = 1'b0;
        tick();

        // Basic fetch with wait states
        do_fetch(32'h8123_0005, 2, 16'h0000);
        check("opcode", opcode, 8);
        check("mm", mm, 1);
        check("imm", imm, 5);

        // Stray ack in IDLE
        imem_if.imem_ack   = 1'b1;
        imem_if.imem_rdata = 32'hDEAD_BEEF;
        tick();
        imem_if.imem_ack   = 1'b0;
        check("stray_ir", ir, 32'h8123_0005);
        check("stray_valid", ir_valid, 0);
        check("stray_req", imem_if.imem_req, 0);

        // Reach pc=7 then fetch with simultaneous increment
        do_fetch(32'h4000_0007, 0, 16'h0000);
        pc_op(1'b1, 1'b0);
        check("abs_7", pc, 16'h0007);
        ir_load = 1'b1; pc_write = 1'b1; pc_sel = 1'b0;
        tick();
        ir_load = 1'b0; pc_write = 1'b0;
        check("inc_pc", pc, 16'h0008);
        check("pre_addr", imem_if.imem_addr, 16'h0007);
        check("req_7", imem_if.imem_req, 1);

        // Overrun in REQ
        ir_load = 1'b1;
        tick();
        ir_load = 1'b0;
        check("ovr_hi", fetch_ovr, 1);
        check("ovr_addr", imem_if.imem_addr, 16'h0007);
        tick();
        check("ovr_lo", fetch_ovr, 0);

        // pc_rst with pc_write during REQ keeps the fetch alive
        pc_rst = 1'b1; pc_write = 1'b1;
        tick();
        pc_rst = 1'b0; pc_write = 1'b0;
        check("pcrst_pc", pc, 0);
        check("pcrst_req", imem_if.imem_req, 1);
        imem_if.imem_ack   = 1'b1;
        imem_if.imem_rdata = 32'h4000_0010;
        tick();
        imem_if.imem_ack   = 1'b0;
        check("ovr_valid", ir_valid, 1);
        check("ovr_ir", ir, 32'h4000_0010);
        tick();
        check("ovr_single", ir_valid, 0);

        // Branches
        pc_op(1'b1, 1'b0);
        check("abs_10", pc, 16'h0010);
        do_fetch(32'h5000_FFFE, 0, 16'h0010);
        pc_op(1'b1, 1'b1);
        check("rel_neg", pc, 16'h000E);
        do_fetch(32'h4000_0040, 1, 16'h000E);
        pc_op(1'b1, 1'b0);
        check("abs_40", pc, 16'h0040);
        do_fetch(32'h4000_FFFF, 0, 16'h0040);
        pc_op(1'b1, 1'b0);
        check("abs_ffff", pc, 16'hFFFF);
        pc_op(1'b0, 1'b0);
        check("wrap", pc, 16'h0000);

        // Reset mid-REQ, late ack ignored
        ir_load = 1'b1;
        tick();
        ir_load = 1'b0;
        check("mid_req", imem_if.imem_req, 1);
        rst = 1'b1;
        #1;
        check("arst_req", imem_if.imem_req, 0);
        check("arst_ir", ir, 0);
        check("arst_busy", fetch_busy, 0);
        tick();
        rst = 1'b0;
        imem_if.imem_ack   = 1'b1;
        imem_if.imem_rdata = 32'hCAFE_F00D;
        tick();
        imem_if.imem_ack   = 1'b0;
        check("late_valid", ir_valid, 0);
        check("late_ir", ir, 0);
        check("late_req", imem_if.imem_req, 0);

`ifdef SISC_FETCH_TIMEOUT_EN
        do_fetch(32'h1234_5678, 0, 16'h0000);
        ir_load = 1'b1;
        tick();
        ir_load = 1'b0;
        repeat (14) tick();
        check("to_wait", imem_if.imem_req, 1);
        check("to_noerr", fetch_err, 0);
        tick();
        check("to_err", fetch_err, 1);
        check("to_ir", ir, 0);
        check("to_valid", ir_valid, 1);
        check("to_req", imem_if.imem_req, 0);
        check("to_busy", fetch_busy, 0);
        tick();
        check("to_sticky", fetch_err, 1);
        check("to_pulse", ir_valid, 0);
`else
        check("err_tied", fetch_err, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
